// File: rtl/shuf_page_ctrl.sv
// Page scheduler for the shuffle-stage coefficient buffer: clears pages ahead of the writer,
// hands full pages to the reader in ring order, and frees them on reader completion.
module shuf_page_ctrl #(
   parameter int PAGES = 3,
   parameter int DEPTH = 64,
   parameter int CLR_W = 8,
   localparam int NSLICE = DEPTH / CLR_W,
   localparam int CLR_AW = (NSLICE > 1) ? $clog2(NSLICE) : 1
) (
   input  logic              clk,
   input  logic              rst,
   output logic              wr_grant,
   output logic [1:0]        wr_page,
   input  logic              wr_start,
   input  logic              wr_done,
   output logic              rd_valid,
   output logic [1:0]        rd_page,
   input  logic              rd_done,
   output logic              clr_en,
   output logic [1:0]        clr_page,
   output logic [CLR_AW-1:0] clr_addr,
   output logic [2:0]        full_cnt,
   output logic              err
);

   typedef enum logic [2:0] {PG_FREE, PG_CLEAR, PG_READY, PG_WRITE, PG_FULL} pg_e;
   typedef enum logic [1:0] {W_IDLE, W_CLEAR, W_READY, W_BUSY} wst_e;

   localparam logic [CLR_AW-1:0] LAST_SLICE = CLR_AW'(NSLICE - 1);

   wst_e              wst_q, wst_d;
   pg_e               page_q [PAGES];
   pg_e               page_d [PAGES];
   logic [1:0]        wr_ptr_q, wr_ptr_d;
   logic [1:0]        rd_ptr_q, rd_ptr_d;
   logic [CLR_AW-1:0] clr_addr_q, clr_addr_d;
   logic              rd_valid_q, rd_valid_d;
   logic [2:0]        full_cnt_q, full_cnt_d;
   logic              err_q, err_d;

   function automatic logic [1:0] ptr_next(input logic [1:0] p);
      return (p == 2'(PAGES - 1)) ? 2'd0 : p + 2'd1;
   endfunction

   always_comb begin
      wst_d      = wst_q;
      page_d     = page_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      clr_addr_d = clr_addr_q;
      wr_grant   = 1'b0;
      clr_en     = 1'b0;

      // Clearing is prefetched as soon as the page under wr_ptr is free.
      case (wst_q)
         W_IDLE: begin
            if (page_q[wr_ptr_q] == PG_FREE) begin
               wst_d              = W_CLEAR;
               page_d[wr_ptr_q]   = PG_CLEAR;
               clr_addr_d         = '0;
            end
         end
         W_CLEAR: begin
            clr_en = 1'b1;
            if (clr_addr_q == LAST_SLICE) begin
               wst_d            = W_READY;
               page_d[wr_ptr_q] = PG_READY;
               clr_addr_d       = '0;
            end else begin
               clr_addr_d = clr_addr_q + 1'b1;
            end
         end
         W_READY: begin
            wr_grant = 1'b1;
            if (wr_start) begin
               wst_d            = W_BUSY;
               page_d[wr_ptr_q] = PG_WRITE;
            end
         end
         W_BUSY: begin
            if (wr_done) begin
               wst_d            = W_IDLE;
               page_d[wr_ptr_q] = PG_FULL;
               wr_ptr_d         = ptr_next(wr_ptr_q);
            end
         end
         default: wst_d = W_IDLE;
      endcase

      if (rd_done && rd_valid_q) begin
         page_d[rd_ptr_q] = PG_FREE;
         rd_ptr_d         = ptr_next(rd_ptr_q);
      end

      err_d = err_q
            | (wr_start && (wst_q != W_READY))
            | (wr_done  && (wst_q != W_BUSY))
            | (rd_done  && !rd_valid_q);

      // Registered from next-state so the reader sees a page the cycle after it fills.
      rd_valid_d = (page_d[rd_ptr_d] == PG_FULL);
      full_cnt_d = '0;
      for (int i = 0; i < PAGES; i++) begin
         if (page_d[i] == PG_FULL) full_cnt_d = full_cnt_d + 3'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wst_q      <= W_IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         clr_addr_q <= '0;
         rd_valid_q <= 1'b0;
         full_cnt_q <= '0;
         err_q      <= 1'b0;
         for (int i = 0; i < PAGES; i++) page_q[i] <= PG_FREE;
      end else begin
         wst_q      <= wst_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         clr_addr_q <= clr_addr_d;
         rd_valid_q <= rd_valid_d;
         full_cnt_q <= full_cnt_d;
         err_q      <= err_d;
         for (int i = 0; i < PAGES; i++) page_q[i] <= page_d[i];
      end
   end

   assign wr_page  = wr_ptr_q;
   assign rd_page  = rd_ptr_q;
   assign clr_page = wr_ptr_q;
   assign clr_addr = clr_addr_q;
   assign rd_valid = rd_valid_q;
   assign full_cnt = full_cnt_q;
   assign err      = err_q;

endmodule

// File: tb/tb_shuf_page_ctrl.sv
// Bench for shuf_page_ctrl: directed scenarios plus randomized traffic against a page-ring model.
module tb_shuf_page_ctrl;
   localparam int PAGES = 3;
   localparam int DEPTH = 64;
   localparam int CLR_W = 8;
   localparam int NSL   = DEPTH / CLR_W;

   localparam int P_FREE = 0, P_CLEAR = 1, P_READY = 2, P_WRITE = 3, P_FULL = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       wr_start = 1'b0, wr_done = 1'b0, rd_done = 1'b0;
   logic       wr_grant, rd_valid, clr_en, err;
   logic [1:0] wr_page, rd_page, clr_page;
   logic [2:0] clr_addr;
   logic [2:0] full_cnt;

   int n_vec  = 0;
   int n_miss = 0;

   // Reference model: per-page state, ring pointers, clear progress, sticky error.
   int m_page [4];
   int m_wp, m_rp, m_clr;
   bit m_err;

   shuf_page_ctrl #(.PAGES(PAGES), .DEPTH(DEPTH), .CLR_W(CLR_W)) dut (
      .clk(clk), .rst(rst),
      .wr_grant(wr_grant), .wr_page(wr_page), .wr_start(wr_start), .wr_done(wr_done),
      .rd_valid(rd_valid), .rd_page(rd_page), .rd_done(rd_done),
      .clr_en(clr_en), .clr_page(clr_page), .clr_addr(clr_addr),
      .full_cnt(full_cnt), .err(err)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      for (int i = 0; i < 4; i++) m_page[i] = P_FREE;
      m_wp = 0; m_rp = 0; m_clr = 0; m_err = 0;
   endtask

   task automatic model_step(input bit ws, input bit wd, input bit rd);
      int np [4];
      int nwp, nrp, nclr;
      np = m_page; nwp = m_wp; nrp = m_rp; nclr = m_clr;
      if (ws) begin
         if (m_page[m_wp] == P_READY) np[m_wp] = P_WRITE; else m_err = 1;
      end
      if (wd) begin
         if (m_page[m_wp] == P_WRITE) begin np[m_wp] = P_FULL; nwp = (m_wp + 1) % PAGES; end
         else m_err = 1;
      end
      if (rd) begin
         if (m_page[m_rp] == P_FULL) begin np[m_rp] = P_FREE; nrp = (m_rp + 1) % PAGES; end
         else m_err = 1;
      end
      if (m_page[m_wp] == P_FREE) begin
         np[m_wp] = P_CLEAR; nclr = 0;
      end else if (m_page[m_wp] == P_CLEAR) begin
         if (m_clr == NSL - 1) np[m_wp] = P_READY; else nclr = m_clr + 1;
      end
      m_page = np; m_wp = nwp; m_rp = nrp; m_clr = nclr;
   endtask

   function automatic int model_full();
      int c = 0;
      for (int i = 0; i < PAGES; i++) if (m_page[i] == P_FULL) c++;
      return c;
   endfunction

   task automatic tick(input bit ws, input bit wd, input bit rd);
      wr_start = ws; wr_done = wd; rd_done = rd;
      @(posedge clk);
      model_step(ws, wd, rd);
      #1;
      wr_start = 1'b0; wr_done = 1'b0; rd_done = 1'b0;
   endtask

   task automatic do_reset();
      wr_start = 1'b0; wr_done = 1'b0; rd_done = 1'b0;
      rst = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic wait_grant(output bit ok);
      ok = 0;
      for (int i = 0; i < 40 && !ok; i++) begin
         if (wr_grant === 1'b1) ok = 1; else tick(0, 0, 0);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      n_vec++;
      if ({wr_grant, rd_valid, clr_en, clr_page, clr_addr, full_cnt, err, wr_page, rd_page} !== '0) begin
         n_miss++;
         $display("FAIL reset_values: got grant=%b rdv=%b clr_en=%b clr_page=%0d clr_addr=%0d full=%0d err=%b wp=%0d rp=%0d, want all 0",
                  wr_grant, rd_valid, clr_en, clr_page, clr_addr, full_cnt, err, wr_page, rd_page);
      end
      rst = 1'b0;
   endtask

   task automatic test_clear_after_reset();
      for (int i = 0; i < NSL; i++) begin
         tick(0, 0, 0);
         n_vec++;
         if (clr_en !== 1'b1 || clr_page !== 2'd0 || clr_addr !== 3'(i) || wr_grant !== 1'b0) begin
            n_miss++;
            $display("FAIL clear_slice%0d: got clr_en=%b page=%0d addr=%0d grant=%b, want 1/0/%0d/0",
                     i, clr_en, clr_page, clr_addr, wr_grant, i);
         end
      end
      tick(0, 0, 0);
      n_vec++;
      if (wr_grant !== 1'b1 || wr_page !== 2'd0 || clr_en !== 1'b0 || full_cnt !== 3'd0) begin
         n_miss++;
         $display("FAIL first_grant: got grant=%b wp=%0d clr_en=%b full=%0d, want 1/0/0/0",
                  wr_grant, wr_page, clr_en, full_cnt);
      end
   endtask

   task automatic test_write_read();
      tick(1, 0, 0);
      n_vec++;
      if (wr_grant !== 1'b0) begin
         n_miss++; $display("FAIL grant_drop: got grant=%b, want 0", wr_grant);
      end
      repeat (19) tick(0, 0, 0);
      tick(0, 1, 0);
      n_vec++;
      if (rd_valid !== 1'b1 || rd_page !== 2'd0 || full_cnt !== 3'd1 || wr_page !== 2'd1 || clr_en !== 1'b0) begin
         n_miss++;
         $display("FAIL first_full: got rdv=%b rp=%0d full=%0d wp=%0d clr_en=%b, want 1/0/1/1/0",
                  rd_valid, rd_page, full_cnt, wr_page, clr_en);
      end
      tick(0, 0, 0);
      n_vec++;
      if (clr_en !== 1'b1 || clr_page !== 2'd1 || clr_addr !== 3'd0) begin
         n_miss++;
         $display("FAIL page1_clear: got clr_en=%b page=%0d addr=%0d, want 1/1/0", clr_en, clr_page, clr_addr);
      end
   endtask

   task automatic test_all_full();
      bit ok;
      for (int b = 0; b < 2; b++) begin
         wait_grant(ok);
         n_vec++;
         if (!ok) begin n_miss++; $display("FAIL grant_timeout_blk%0d: got no grant, want grant", b); end
         tick(1, 0, 0);
         tick(0, 1, 0);
      end
      repeat (5) tick(0, 0, 0);
      n_vec++;
      if (full_cnt !== 3'd3 || wr_grant !== 1'b0 || clr_en !== 1'b0 || wr_page !== 2'd0) begin
         n_miss++;
         $display("FAIL all_full_stall: got full=%0d grant=%b clr_en=%b wp=%0d, want 3/0/0/0",
                  full_cnt, wr_grant, clr_en, wr_page);
      end
      tick(0, 0, 1);
      n_vec++;
      if (rd_page !== 2'd1 || full_cnt !== 3'd2 || rd_valid !== 1'b1) begin
         n_miss++;
         $display("FAIL free_page0: got rp=%0d full=%0d rdv=%b, want 1/2/1", rd_page, full_cnt, rd_valid);
      end
      wait_grant(ok);
      n_vec++;
      if (!ok || wr_page !== 2'd0) begin
         n_miss++; $display("FAIL wrap_grant: got ok=%b wp=%0d, want 1/0", ok, wr_page);
      end
   endtask

   task automatic test_simultaneous();
      tick(1, 0, 0);
      tick(0, 0, 1);
      n_vec++;
      if (full_cnt !== 3'd1 || rd_page !== 2'd2) begin
         n_miss++; $display("FAIL pre_simul: got full=%0d rp=%0d, want 1/2", full_cnt, rd_page);
      end
      tick(0, 1, 1);
      n_vec++;
      if (full_cnt !== 3'd1 || rd_page !== 2'd0 || wr_page !== 2'd1 || rd_valid !== 1'b1 || err !== 1'b0) begin
         n_miss++;
         $display("FAIL simul_done: got full=%0d rp=%0d wp=%0d rdv=%b err=%b, want 1/0/1/1/0",
                  full_cnt, rd_page, wr_page, rd_valid, err);
      end
   endtask

   task automatic test_errors();
      do_reset();
      tick(0, 1, 0);
      n_vec++;
      if (err !== 1'b1 || full_cnt !== 3'd0 || rd_valid !== 1'b0 || wr_page !== 2'd0) begin
         n_miss++;
         $display("FAIL err_wr_done: got err=%b full=%0d rdv=%b wp=%0d, want 1/0/0/0", err, full_cnt, rd_valid, wr_page);
      end
      repeat (3) tick(0, 0, 0);
      n_vec++;
      if (err !== 1'b1) begin n_miss++; $display("FAIL err_sticky: got err=%b, want 1", err); end

      do_reset();
      tick(0, 0, 1);
      n_vec++;
      if (err !== 1'b1 || rd_page !== 2'd0 || full_cnt !== 3'd0) begin
         n_miss++; $display("FAIL err_rd_done: got err=%b rp=%0d full=%0d, want 1/0/0", err, rd_page, full_cnt);
      end

      do_reset();
      tick(0, 0, 0);
      tick(1, 0, 0);
      n_vec++;
      if (err !== 1'b1 || wr_grant !== 1'b0 || clr_en !== 1'b1 || clr_addr !== 3'd1) begin
         n_miss++;
         $display("FAIL err_wr_start: got err=%b grant=%b clr_en=%b addr=%0d, want 1/0/1/1", err, wr_grant, clr_en, clr_addr);
      end
   endtask

   task automatic test_reset_mid_clear();
      do_reset();
      repeat (4) tick(0, 0, 0);
      n_vec++;
      if (clr_en !== 1'b1 || clr_addr !== 3'd3) begin
         n_miss++; $display("FAIL mid_clear_pre: got clr_en=%b addr=%0d, want 1/3", clr_en, clr_addr);
      end
      #2 rst = 1'b1;
      #1;
      model_reset();
      n_vec++;
      if ({wr_grant, rd_valid, clr_en, clr_page, clr_addr, full_cnt, err, wr_page, rd_page} !== '0) begin
         n_miss++;
         $display("FAIL async_reset: got clr_en=%b addr=%0d grant=%b full=%0d err=%b, want all 0",
                  clr_en, clr_addr, wr_grant, full_cnt, err);
      end
      #2 rst = 1'b0;
      tick(0, 0, 0);
      n_vec++;
      if (clr_en !== 1'b1 || clr_addr !== 3'd0 || clr_page !== 2'd0) begin
         n_miss++; $display("FAIL clear_restart: got clr_en=%b addr=%0d page=%0d, want 1/0/0", clr_en, clr_addr, clr_page);
      end
   endtask

   task automatic test_random();
      bit ws, wd, rd;
      bit e_grant, e_rdv, e_clr;
      do_reset();
      for (int c = 0; c < 2000; c++) begin
         ws = (m_page[m_wp] == P_READY) && ($urandom_range(0, 1) == 1);
         wd = (m_page[m_wp] == P_WRITE) && ($urandom_range(0, 5) == 0);
         rd = (m_page[m_rp] == P_FULL)  && ($urandom_range(0, 3) == 0);
         tick(ws, wd, rd);
         e_grant = (m_page[m_wp] == P_READY);
         e_rdv   = (m_page[m_rp] == P_FULL);
         e_clr   = (m_page[m_wp] == P_CLEAR);
         n_vec++;
         if (wr_grant !== e_grant || rd_valid !== e_rdv || clr_en !== e_clr ||
             wr_page !== 2'(m_wp) || rd_page !== 2'(m_rp) || full_cnt !== 3'(model_full()) || err !== m_err ||
             (e_clr && (clr_addr !== 3'(m_clr) || clr_page !== 2'(m_wp)))) begin
            n_miss++;
            $display("FAIL random_c%0d: got grant=%b rdv=%b clr=%b addr=%0d wp=%0d rp=%0d full=%0d err=%b, want %b/%b/%b/%0d/%0d/%0d/%0d/%b",
                     c, wr_grant, rd_valid, clr_en, clr_addr, wr_page, rd_page, full_cnt, err,
                     e_grant, e_rdv, e_clr, m_clr, m_wp, m_rp, model_full(), m_err);
         end
      end
   endtask

   initial begin
      test_reset();
      test_clear_after_reset();
      test_write_read();
      test_all_full();
      test_simultaneous();
      test_errors();
      test_reset_mid_clear();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/shuf_page_ctrl.md
# shuf_page_ctrl

Page scheduler for the shuffle-stage block buffer. It owns a ring of PAGES coefficient pages shared between the dequantize/zigzag writer and the IDCT reader. It clears each page before handing it to the writer, publishes completed pages to the reader in strict ring order, and frees them when the reader is finished. It replaces free-running page rotation with an explicit handshake, so neither side can overrun the other.

## Interface
- PAGES, 3, number of buffer pages (2..4)
- DEPTH, 64, 16-bit entries per page
- CLR_W, 8, entries zeroed per clear cycle; DEPTH must be a multiple of CLR_W
- clk  in  1  clock, rising edge
- rst  in  1  reset; asynchronous, active-high
- wr_grant  out  1  cleared page available to the writer
- wr_page  out  2  page index the writer must use (valid while wr_grant or writer busy)
- wr_start  in  1  pulse; writer takes the granted page
- wr_done  in  1  pulse; writer finished the block (all coefficients written)
- rd_valid  out  1  full page available to the reader
- rd_page  out  2  page index to read (valid while rd_valid)
- rd_done  in  1  pulse; reader finished with rd_page
- clr_en  out  1  buffer zero-write enable
- clr_page  out  2  page being cleared
- clr_addr  out  $clog2(DEPTH/CLR_W)  clear slice; covers entries clr_addr*CLR_W .. +CLR_W-1
- full_cnt  out  3  number of pages in FULL state
- err  out  1  sticky protocol-violation flag

## Operation
- Each page has a state: FREE, CLEAR, READY, WRITE or FULL. wr_ptr and rd_ptr advance in the order 0,1,..,PAGES-1,0.
- Write FSM states: W_IDLE, W_CLEAR, W_READY, W_BUSY.
  - W_IDLE: if page[wr_ptr]==FREE, go to W_CLEAR with clr_addr=0. Clearing is prefetched; it does not wait for a writer request.
  - W_CLEAR: clr_en=1 and clr_page=wr_ptr. clr_addr increments every cycle. After slice DEPTH/CLR_W-1, go to W_READY.
  - W_READY: wr_grant=1. On wr_start, go to W_BUSY.
  - W_BUSY: wr_grant=0. On wr_done, page[wr_ptr] becomes FULL, wr_ptr advances, and the FSM returns to W_IDLE.
- Read side:
  - rd_valid = (page[rd_ptr]==FULL), registered.
  - On rd_done while rd_valid: the page becomes FREE and rd_ptr advances.
- full_cnt is the registered count of FULL pages, range 0..PAGES.
- err is set and held until reset on any of:
  - wr_start outside W_READY;
  - wr_done outside W_BUSY;
  - rd_done while !rd_valid.
  The offending pulse is otherwise ignored.
- wr_page equals wr_ptr. rd_page equals rd_ptr.

## Timing
- Reset values: wr_grant=0, rd_valid=0, clr_en=0, clr_page=0, clr_addr=0, full_cnt=0, err=0, wr_page=0, rd_page=0. All pages FREE, both pointers 0, write FSM in W_IDLE.
- Clear after reset:
  - First edge after reset release: W_CLEAR.
  - clr_en is high for exactly DEPTH/CLR_W cycles (8 at defaults).
  - wr_grant rises on the cycle after the last clear slice.
- wr_start sampled at edge t: wr_grant is low from t+1.
- wr_done sampled at edge t:
  - page is FULL and full_cnt updated at t+1;
  - rd_valid rises at t+1 if rd_ptr points to that page;
  - W_IDLE at t+1; clearing of the next page starts at t+2 if it is FREE.
- rd_done at edge t:
  - page is FREE and rd_valid re-evaluated for the new rd_ptr at t+1;
  - a write FSM waiting in W_IDLE on that page enters W_CLEAR at t+2.
- Simultaneous wr_done and rd_done: both take effect in the same cycle. full_cnt reflects both, for a net change of 0.
- All pages FULL: the write FSM stays in W_IDLE with wr_grant=0, which stalls the writer. Nothing is dropped.
- No FULL page: rd_valid=0 and rd_done is an error.
- Pointer wrap: PAGES-1 goes to 0, with no bubble.
- Reset mid-clear or mid-write aborts immediately. Page contents are undefined but are always re-cleared before their next grant.

## Test plan
- Reset release, no other stimulus -> clr_en high for 8 cycles on page 0, clr_addr 0..7, then wr_grant=1 with wr_page=0; full_cnt=0.
- wr_start, then wr_done 20 cycles later -> rd_valid=1 and rd_page=0 the next cycle, full_cnt=1; page 1 clear starts one cycle later.
- Reader never responds; three blocks written -> full_cnt=3, wr_grant stays 0. One rd_done -> page 0 freed, cleared, and granted; wr_page=0 after the wrap.
- wr_done and rd_done in the same cycle with full_cnt=1 -> full_cnt stays 1, rd_page and wr_page both advance.
- wr_done with no prior wr_start, and rd_done with rd_valid=0 -> err=1 and sticky, page states unchanged.
- Assert rst in the 4th clear cycle -> all outputs return to reset values asynchronously; after release, the clear restarts on page 0 at clr_addr=0.
